cd_req_initiator: RTL and testbench
===================================

CD_REQ_INITIATOR -- requirements
Module: cd_req_initiator

Interface
REQ-001 SHALL have parameter DATA_W, default 64: flit width in bits; minimum 64.
REQ-002 SHALL have parameter BURST, default 2: number of reply flits per request, 1..4.
REQ-003 SHALL have parameter MAX_OUT, default 4: maximum outstanding requests, 1..16.
REQ-004 SHALL have port clk, input, 1: the single clock; every flop is clocked on its rising edge.
REQ-005 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-006 SHALL have port start, input, 1: a one-cycle pulse that launches a run; ignored unless the FSM is in IDLE.
REQ-007 SHALL have port num_req, input, 8: number of requests to issue in the run; sampled when start is accepted.
REQ-008 SHALL have port src_id, input, 2: source id of this initiator; sampled when start is accepted.
REQ-009 SHALL have ports req_so (output, 1), req_ro (input, 1) and req_do (output, DATA_W): the request send port.
REQ-010 SHALL have ports rsp_si (input, 1), rsp_ri (output, 1) and rsp_di (input, DATA_W): the reply receive port.
REQ-011 SHALL have port busy, output, 1: high in ISSUE and DRAIN.
REQ-012 SHALL have port done, output, 1: a one-cycle pulse on entry to DONE.
REQ-013 SHALL have ports req_cnt (output, 8) and rsp_cnt (output, 8): requests sent, and complete bursts received.
REQ-014 SHALL have port err, output, 1: sticky error flag.

Function
REQ-015 SHALL count a flit as transferred only in a cycle where valid and ready are both high (req_so&req_ro, or rsp_si&rsp_ri).
REQ-016 SHALL lay out every flit as: [63:62] kind (01 = request, 10 = reply); [61:60] src; [59:58] llc; [57:56] beat; [55:52] tag; [51:0] addr; bits at index 64 and above are zero.
REQ-017 SHALL build request n (n counting from 0) with kind = 01, src = src_id, llc = n[1:0], beat = 0, tag = n[3:0] mod MAX_OUT, addr = zero-extended n.
REQ-018 SHALL implement FSM states IDLE, ISSUE, DRAIN and DONE.
REQ-019 SHALL move IDLE->ISSUE on start when num_req != 0, and IDLE->DONE on start when num_req == 0.
REQ-020 SHALL move ISSUE->DRAIN on the cycle the last request transfers.
REQ-021 SHALL move DRAIN->DONE when the outstanding bitmap is zero.
REQ-022 SHALL move DONE->IDLE unconditionally after one cycle.
REQ-023 SHALL assert req_so only in ISSUE, only when the bit for the next tag is clear, and only when the outstanding count < MAX_OUT.
REQ-024 SHALL hold req_do stable while req_so is high and req_ro is low.
REQ-025 SHALL set the tag's bit in the outstanding bitmap and increment req_cnt on each request transfer, with no wrap (at most 255).
REQ-026 SHALL drive rsp_ri = 1 in every state except IDLE after reset, so that replies are always sunk.
REQ-027 SHALL accept reply beats in order 0..BURST-1 per tag; on beat BURST-1, clear the tag's bit and increment rsp_cnt.
REQ-028 SHALL set err on a reply whose kind != 10, whose src != src_id, whose tag bit is clear, or whose beat is out of sequence; such a reply is dropped without changing the bitmap.
REQ-029 SHALL give priority to the set when a request set and a reply clear target the same tag in the same cycle; this case is unreachable under REQ-023 but remains defined.
REQ-030 SHALL preserve req_cnt, rsp_cnt and err through DONE and IDLE, and clear them on the next accepted start.
REQ-031 SHALL drop any reply that arrives while the FSM is in IDLE and set err.

Reset
REQ-032 SHALL, while reset is high, force: state = IDLE; req_so = 0; req_do = 0; rsp_ri = 0; busy = 0; done = 0; req_cnt = 0; rsp_cnt = 0; err = 0; bitmap = 0; beat trackers = 0.
REQ-033 SHALL abort a run when reset is asserted mid-run, with no further flits emitted.

Structure
REQ-034 SHALL place the flit field offsets, the kind encodings and the FSM state encodings in a shared package cd_pkt_pkg, which the LLC-proxy side also uses.
REQ-035 SHALL implement the outstanding bitmap and per-tag beat counters as one sub-module, cd_tag_tracker (set, clear, query, count).

Verification
REQ-036 SHALL cover: num_req = 4, req_ro = 1, ideal BURST = 2 responder -> 4 requests with tags 0..3 and llc 0..3, rsp_cnt = 4, done pulses once, err = 0.
REQ-037 SHALL cover: num_req = 10, MAX_OUT = 4, responder delays replies by 20 cycles -> no more than 4 outstanding at once, req_cnt = 10, rsp_cnt = 10.
REQ-038 SHALL cover: req_ro toggled 1010 during ISSUE -> req_do stable while stalled, no duplicate or lost request.
REQ-039 SHALL cover: a reply with tag 7 while only tags 0..3 are outstanding -> err = 1, bitmap unchanged.
REQ-040 SHALL cover: start with num_req = 0 -> done on the next cycle, req_so never asserted.
REQ-041 SHALL cover: reset asserted in DRAIN with 2 outstanding -> all outputs at reset values the following cycle, FSM in IDLE.

Source files
------------

// File: rtl/cd_pkt_pkg.sv
// Shared flit definitions for the coherence-directory request path.
// Contents: flit field offsets, the kind encodings, the initiator FSM state
// encoding, and a helper that packs the flit fields into a 64-bit flit.
// The LLC-proxy side imports the same package, so both ends decode the
// same layout.
package cd_pkt_pkg;

  localparam int FLIT_W  = 64;
  localparam int KIND_LO = 62;   // [63:62]
  localparam int SRC_LO  = 60;   // [61:60]
  localparam int LLC_LO  = 58;   // [59:58]
  localparam int BEAT_LO = 56;   // [57:56]
  localparam int TAG_LO  = 52;   // [55:52]
  localparam int TAG_W   = 4;
  localparam int ADDR_W  = 52;   // [51:0]

  localparam logic [1:0] KIND_REQ = 2'b01;
  localparam logic [1:0] KIND_RSP = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } cd_state_e;

  function automatic logic [FLIT_W-1:0] make_flit(
    input logic [1:0]        kind,
    input logic [1:0]        src,
    input logic [1:0]        llc,
    input logic [1:0]        beat,
    input logic [TAG_W-1:0]  tag,
    input logic [ADDR_W-1:0] addr
  );
    logic [FLIT_W-1:0] f;
    f                   = '0;
    f[KIND_LO +: 2]     = kind;
    f[SRC_LO  +: 2]     = src;
    f[LLC_LO  +: 2]     = llc;
    f[BEAT_LO +: 2]     = beat;
    f[TAG_LO  +: TAG_W] = tag;
    f[0 +: ADDR_W]      = addr;
    return f;
  endfunction

endpackage

// File: rtl/cd_tag_tracker.sv
// Outstanding-tag tracker: one bit per tag plus a per-tag expected-beat
// counter.
// Ports:
//   clk, reset            - clock, synchronous active-high reset
//   set_i, set_tag_i      - mark a tag outstanding (request transferred)
//   adv_i                 - accept one reply beat for rsp_tag_i; the last beat
//                           of a burst clears the tag
//   req_tag_i/req_busy_o  - query: is the next request's tag still in use
//   rsp_tag_i             - reply tag being examined
//   rsp_busy_o            - that tag is outstanding
//   rsp_beat_o            - the beat expected next on that tag
//   count_o               - number of outstanding tags
module cd_tag_tracker
  import cd_pkt_pkg::*;
#(
  parameter int MAX_OUT = 4,
  parameter int BURST   = 2,
  parameter int CNT_W   = $clog2(MAX_OUT + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             set_i,
  input  logic [TAG_W-1:0] set_tag_i,
  input  logic             adv_i,
  input  logic [TAG_W-1:0] req_tag_i,
  output logic             req_busy_o,
  input  logic [TAG_W-1:0] rsp_tag_i,
  output logic             rsp_busy_o,
  output logic [1:0]       rsp_beat_o,
  output logic [CNT_W-1:0] count_o
);

  logic [MAX_OUT-1:0] bitmap_q, bitmap_d;
  logic [1:0]         beat_q [MAX_OUT];
  logic [1:0]         beat_d [MAX_OUT];

  // Tags at or above MAX_OUT match no entry and so read back as not busy.
  always_comb begin
    // NOTE: every output of a combinational block gets a default before any
    // branch, otherwise an unassigned path infers a latch.
    req_busy_o = 1'b0;
    rsp_busy_o = 1'b0;
    rsp_beat_o = 2'd0;
    count_o    = '0;
    for (int i = 0; i < MAX_OUT; i++) begin
      if (req_tag_i == TAG_W'(i)) req_busy_o = bitmap_q[i];
      if (rsp_tag_i == TAG_W'(i)) begin
        rsp_busy_o = bitmap_q[i];
        rsp_beat_o = beat_q[i];
      end
      count_o = count_o + CNT_W'(bitmap_q[i]);
    end
  end

  always_comb begin
    bitmap_d = bitmap_q;
    beat_d   = beat_q;
    for (int i = 0; i < MAX_OUT; i++) begin
      if (adv_i && rsp_tag_i == TAG_W'(i)) begin
        if (beat_q[i] == 2'(BURST - 1)) begin
          bitmap_d[i] = 1'b0;
          beat_d[i]   = 2'd0;
        end else begin
          beat_d[i] = beat_q[i] + 2'd1;
        end
      end
      // Evaluated after the clear so a same-cycle set on the same tag wins.
      if (set_i && set_tag_i == TAG_W'(i)) begin
        bitmap_d[i] = 1'b1;
        beat_d[i]   = 2'd0;
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: the per-tag beat counters are plain flops, not RAM, and are reset
    // like any other state; a stale beat would reject the first good reply.
    if (reset) begin
      bitmap_q <= '0;
      for (int i = 0; i < MAX_OUT; i++) beat_q[i] <= 2'd0;
    end else begin
      bitmap_q <= bitmap_d;
      beat_q   <= beat_d;
    end
  end

endmodule

// File: rtl/cd_req_initiator.sv
// Request initiator: on start, issues num_req request flits (tag reused
// modulo MAX_OUT, never more than MAX_OUT outstanding), sinks BURST-beat
// replies, checks them, and signals done once every tag has drained.
// Ports:
//   clk, reset               - clock, synchronous active-high reset
//   start, num_req, src_id   - launch a run (accepted only in IDLE)
//   req_so/req_ro/req_do     - request send port (valid/ready/data)
//   rsp_si/rsp_ri/rsp_di     - reply receive port (valid/ready/data)
//   busy                     - high in ISSUE and DRAIN
//   done                     - one-cycle pulse in DONE
//   req_cnt, rsp_cnt         - requests sent, complete bursts received
//   err                      - sticky protocol error
module cd_req_initiator
  import cd_pkt_pkg::*;
#(
  parameter int DATA_W  = 64,
  parameter int BURST   = 2,
  parameter int MAX_OUT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        num_req,
  input  logic [1:0]        src_id,
  output logic              req_so,
  input  logic              req_ro,
  output logic [DATA_W-1:0] req_do,
  input  logic              rsp_si,
  output logic              rsp_ri,
  input  logic [DATA_W-1:0] rsp_di,
  output logic              busy,
  output logic              done,
  output logic [7:0]        req_cnt,
  output logic [7:0]        rsp_cnt,
  output logic              err
);

  localparam int CNT_W = $clog2(MAX_OUT + 1);

  cd_state_e        state_q, state_d;
  logic [7:0]       num_q, num_d;
  logic [1:0]       src_q, src_d;
  logic [7:0]       req_cnt_q, req_cnt_d;
  logic [7:0]       rsp_cnt_q, rsp_cnt_d;
  logic             err_q, err_d;
  logic             armed_q, armed_d;   // first start seen since reset

  logic [TAG_W-1:0] next_tag;
  logic             req_fire, last_req;
  logic             rsp_fire, rsp_ok, rsp_adv, rsp_last, rsp_bad;
  logic             trk_req_busy, trk_rsp_busy;
  logic [1:0]       trk_rsp_beat;
  logic [CNT_W-1:0] trk_count;
  logic             unused_rsp;

  // Every data bit reaches the parity only so that lint sees it consumed;
  // the address and the high bits of a reply carry nothing we check.
  assign unused_rsp = ^rsp_di;

  // Request n = req_cnt_q: the index only moves on a transfer, so req_do
  // stays put while the receiver stalls.
  assign next_tag = TAG_W'(32'(req_cnt_q[3:0]) % MAX_OUT);

  always_comb begin
    req_so = !reset && state_q == ST_ISSUE && !trk_req_busy
             && (32'(trk_count) < MAX_OUT);
    req_do = '0;
    if (req_so)
      req_do = DATA_W'(make_flit(KIND_REQ, src_q, req_cnt_q[1:0], 2'd0,
                                 next_tag, ADDR_W'(req_cnt_q)));
    req_fire = req_so && req_ro;
    last_req = req_fire && ({1'b0, req_cnt_q} + 9'd1 == {1'b0, num_q});

    rsp_ri   = !reset && armed_q;
    rsp_fire = rsp_si && rsp_ri;
    rsp_ok   = state_q != ST_IDLE
               && rsp_di[KIND_LO +: 2] == KIND_RSP
               && rsp_di[SRC_LO +: 2] == src_q
               && trk_rsp_busy
               && rsp_di[BEAT_LO +: 2] == trk_rsp_beat;
    rsp_adv  = rsp_fire && rsp_ok;
    rsp_last = rsp_adv && trk_rsp_beat == 2'(BURST - 1);
    rsp_bad  = rsp_fire && !rsp_ok;

    busy = !reset && (state_q == ST_ISSUE || state_q == ST_DRAIN);
    done = !reset && state_q == ST_DONE;
  end

  always_comb begin
    state_d   = state_q;
    num_d     = num_q;
    src_d     = src_q;
    req_cnt_d = req_cnt_q;
    rsp_cnt_d = rsp_cnt_q;
    err_d     = err_q;
    armed_d   = armed_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          num_d     = num_req;
          src_d     = src_id;
          armed_d   = 1'b1;
          req_cnt_d = 8'd0;
          rsp_cnt_d = 8'd0;
          err_d     = 1'b0;
          state_d   = (num_req == 8'd0) ? ST_DONE : ST_ISSUE;
        end
      end
      ST_ISSUE: if (last_req) state_d = ST_DRAIN;
      ST_DRAIN: if (trk_count == '0) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    // Neither transfer can fire in IDLE, so these never collide with the
    // clear on start.
    if (req_fire && req_cnt_q != 8'hFF) req_cnt_d = req_cnt_q + 8'd1;
    if (rsp_last && rsp_cnt_q != 8'hFF) rsp_cnt_d = rsp_cnt_q + 8'd1;
    // A bad reply arriving with start still flags; the run opens with err set.
    if (rsp_bad) err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (reset) begin
      state_q   <= ST_IDLE;
      num_q     <= 8'd0;
      src_q     <= 2'd0;
      req_cnt_q <= 8'd0;
      rsp_cnt_q <= 8'd0;
      err_q     <= 1'b0;
      armed_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      num_q     <= num_d;
      src_q     <= src_d;
      req_cnt_q <= req_cnt_d;
      rsp_cnt_q <= rsp_cnt_d;
      err_q     <= err_d;
      armed_q   <= armed_d;
    end
  end

  assign req_cnt = req_cnt_q;
  assign rsp_cnt = rsp_cnt_q;
  assign err     = err_q;

  cd_tag_tracker #(
    .MAX_OUT (MAX_OUT),
    .BURST   (BURST),
    .CNT_W   (CNT_W)
  ) u_tracker (
    .clk        (clk),
    .reset      (reset),
    .set_i      (req_fire),
    .set_tag_i  (next_tag),
    .adv_i      (rsp_adv),
    .req_tag_i  (next_tag),
    .req_busy_o (trk_req_busy),
    .rsp_tag_i  (rsp_di[TAG_LO +: TAG_W]),
    .rsp_busy_o (trk_rsp_busy),
    .rsp_beat_o (trk_rsp_beat),
    .count_o    (trk_count)
  );

endmodule

// File: tb/tb_cd_req_initiator.sv
// Bench for cd_req_initiator (DATA_W=64, BURST=2, MAX_OUT=4).
// A responder process captures request transfers, replies in order after a
// configurable delay, and can inject single hand-built reply flits.
module tb_cd_req_initiator;

  localparam int BURST   = 2;
  localparam int MAX_OUT = 4;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [7:0]  num_req;
  logic [1:0]  src_id;
  logic        req_so, req_ro;
  logic [63:0] req_do;
  logic        rsp_si, rsp_ri;
  logic [63:0] rsp_di;
  logic        busy, done, err;
  logic [7:0]  req_cnt, rsp_cnt;

  always #5 clk = ~clk;

  cd_req_initiator #(.DATA_W(64), .BURST(BURST), .MAX_OUT(MAX_OUT)) dut (
    .clk(clk), .reset(reset), .start(start), .num_req(num_req), .src_id(src_id),
    .req_so(req_so), .req_ro(req_ro), .req_do(req_do),
    .rsp_si(rsp_si), .rsp_ri(rsp_ri), .rsp_di(rsp_di),
    .busy(busy), .done(done), .req_cnt(req_cnt), .rsp_cnt(rsp_cnt), .err(err)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Independent model of request n for MAX_OUT = 4.
  function automatic logic [63:0] exp_req(input int n, input logic [1:0] src);
    logic [7:0] nb;
    logic [3:0] t;
    nb = 8'(n);
    t  = 4'(n % 4);
    return {2'b01, src, nb[1:0], 2'b00, t, 44'd0, nb};
  endfunction

  function automatic logic [63:0] mk_reply(input logic [63:0] rq, input int b);
    logic [63:0] f;
    f          = rq;
    f[63:62]   = 2'b10;
    f[57:56]   = 2'(b);
    return f;
  endfunction

  // ---------------- responder / monitor ----------------
  typedef struct { logic [63:0] flit; int due; } pend_t;
  pend_t       pend_q[$];
  logic [63:0] req_log[$];
  int          cyc = 0;
  int          ro_mode, resp_delay;
  int          beat_idx = 0;
  int          sent_n, done_bursts, max_outst, done_pulses, stall_viol;
  bit          req_so_seen;
  bit          inj_req, inj_active;
  logic [63:0] inj_flit;
  bit          stall_prev = 1'b0;
  logic [63:0] stall_flit;
  logic        rf, sf;
  logic [63:0] cap;
  int          outst;

  initial begin : responder
    forever begin
      @(negedge clk);
      rf  = req_so & req_ro;
      sf  = rsp_si & rsp_ri;
      cap = req_do;
      if (done === 1'b1) done_pulses++;
      if (req_so === 1'b1) req_so_seen = 1'b1;
      if (stall_prev && req_so && (req_do !== stall_flit)) stall_viol++;
      stall_prev = req_so & ~req_ro;
      stall_flit = req_do;
      @(posedge clk);
      #1;
      cyc++;
      if (reset) begin
        pend_q.delete();
        beat_idx   = 0;
        inj_active = 1'b0;
        stall_prev = 1'b0;
      end else begin
        if (rf) begin
          req_log.push_back(cap);
          pend_q.push_back('{cap, cyc + resp_delay});
          sent_n++;
        end
        if (sf) begin
          if (inj_active) inj_active = 1'b0;
          else begin
            beat_idx++;
            if (beat_idx == BURST) begin
              beat_idx = 0;
              void'(pend_q.pop_front());
              done_bursts++;
            end
          end
        end
      end
      outst = sent_n - done_bursts;
      if (outst > max_outst) max_outst = outst;
      req_ro = (ro_mode == 0) ? 1'b1 : (ro_mode == 1) ? 1'((cyc % 2) == 0) : 1'b0;
      if (inj_req && beat_idx == 0 && !inj_active) begin
        inj_active = 1'b1;
        inj_req    = 1'b0;
      end
      if (inj_active) begin
        rsp_si = 1'b1;
        rsp_di = inj_flit;
      end else if (pend_q.size() > 0 && cyc >= pend_q[0].due) begin
        rsp_si = 1'b1;
        rsp_di = mk_reply(pend_q[0].flit, beat_idx);
      end else begin
        rsp_si = 1'b0;
        rsp_di = '0;
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1, "watchdog");
  end

  // ---------------- vector table ----------------
  typedef struct {
    int         nreq;
    logic [1:0] src;
    int         mode;     // 0: req_ro=1, 1: req_ro toggles 1010
    int         dly;      // reply delay in cycles
    int         exp_req;
    int         exp_rsp;
    bit         exp_err;
    int         lim;      // max outstanding allowed
  } vec_t;

  vec_t vecs[5];

  task automatic clear_model();
    req_log.delete();
    sent_n = 0; done_bursts = 0; max_outst = 0;
    done_pulses = 0; stall_viol = 0; req_so_seen = 1'b0;
  endtask

  task automatic launch(input int nreq, input logic [1:0] src);
    @(posedge clk); #1;
    num_req = 8'(nreq);
    src_id  = src;
    start   = 1'b1;
    @(posedge clk); #1;
    start   = 1'b0;
  endtask

  task automatic wait_done(input string name);
    bit to = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (done_pulses > 0) begin to = 1'b0; break; end
    end
    check({name, "_timeout"}, 64'(to), 64'd0);
  endtask

  task automatic wait_sent(input string name, input int n);
    bit to = 1'b1;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (sent_n >= n) begin to = 1'b0; break; end
    end
    check({name, "_timeout"}, 64'(to), 64'd0);
  endtask

  task automatic inject(input string name, input logic [63:0] f);
    bit to = 1'b1;
    @(posedge clk); #1;
    inj_flit = f;
    inj_req  = 1'b1;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (!inj_req && !inj_active) begin to = 1'b0; break; end
    end
    check({name, "_timeout"}, 64'(to), 64'd0);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    string p;
    p = $sformatf("v%0d", idx);
    ro_mode    = v.mode;
    resp_delay = v.dly;
    clear_model();
    launch(v.nreq, v.src);
    wait_done(p);
    repeat (4) @(negedge clk);
    check({p, "_req_cnt"},  64'(req_cnt), 64'(v.exp_req));
    check({p, "_rsp_cnt"},  64'(rsp_cnt), 64'(v.exp_rsp));
    check({p, "_err"},      64'(err),     64'(v.exp_err));
    check({p, "_done_once"}, 64'(done_pulses), 64'd1);
    check({p, "_n_flits"},  64'(req_log.size()), 64'(v.exp_req));
    check({p, "_max_out_ok"}, 64'(max_outst <= v.lim), 64'd1);
    check({p, "_stable"},   64'(stall_viol), 64'd0);
    check({p, "_idle"},     64'(busy), 64'd0);
    for (int k = 0; k < req_log.size() && k < v.exp_req; k++)
      check($sformatf("%s_req%0d", p, k), req_log[k], exp_req(k, v.src));
  endtask

  initial begin : main
    reset = 1'b1; start = 1'b0; num_req = '0; src_id = '0;
    req_ro = 1'b0; rsp_si = 1'b0; rsp_di = '0;
    ro_mode = 0; resp_delay = 0; inj_req = 1'b0; inj_active = 1'b0; inj_flit = '0;
    clear_model();

    vecs[0] = '{4,  2'd1, 0, 0,  4,  4,  1'b0, 4};   // basic run, tags/llc 0..3
    vecs[1] = '{10, 2'd2, 0, 20, 10, 10, 1'b0, 4};   // slow responder, window limit
    vecs[2] = '{6,  2'd3, 1, 0,  6,  6,  1'b0, 4};   // req_ro toggling 1010
    vecs[3] = '{1,  2'd0, 0, 0,  1,  1,  1'b0, 1};   // single request
    vecs[4] = '{17, 2'd1, 1, 3,  17, 17, 1'b0, 4};   // tag wrap, stalls and delay

    // Reset values.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req_so",  64'(req_so),  64'd0);
    check("rst_req_do",  req_do,       64'd0);
    check("rst_rsp_ri",  64'(rsp_ri),  64'd0);
    check("rst_busy",    64'(busy),    64'd0);
    check("rst_done",    64'(done),    64'd0);
    check("rst_req_cnt", 64'(req_cnt), 64'd0);
    check("rst_rsp_cnt", 64'(rsp_cnt), 64'd0);
    check("rst_err",     64'(err),     64'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    // num_req = 0: done on the next cycle, no request.
    clear_model();
    @(posedge clk); #1;
    num_req = 8'd0; src_id = 2'd1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check("zero_done_next", 64'(done), 64'd1);
    repeat (3) @(negedge clk);
    check("zero_done_once", 64'(done_pulses), 64'd1);
    check("zero_no_req_so", 64'(req_so_seen), 64'd0);
    check("zero_req_cnt",   64'(req_cnt),     64'd0);

    foreach (vecs[i]) run_vec(vecs[i], i);

    // Stray reply while IDLE: dropped, err set.
    inject("idle_inj", {2'b10, 2'b01, 2'b00, 2'b00, 4'd0, 52'd0});
    @(negedge clk);
    check("idle_err",     64'(err),     64'd1);
    check("idle_rsp_cnt", 64'(rsp_cnt), 64'(vecs[4].exp_rsp));
    check("idle_busy",    64'(busy),    64'd0);

    // Reply with tag 7 while tags 0..3 are outstanding.
    ro_mode = 0; resp_delay = 40;
    clear_model();
    launch(4, 2'd1);
    @(negedge clk);
    check("t7_err_cleared", 64'(err), 64'd0);
    wait_sent("t7_sent", 4);
    check("t7_req_cnt_pre", 64'(req_cnt), 64'd4);
    inject("t7_inj", {2'b10, 2'b01, 2'b11, 2'b00, 4'd7, 52'd7});
    @(negedge clk);
    check("t7_err",       64'(err),     64'd1);
    check("t7_rsp_cnt",   64'(rsp_cnt), 64'd0);
    check("t7_busy",      64'(busy),    64'd1);
    wait_done("t7");
    @(negedge clk);
    check("t7_rsp_final", 64'(rsp_cnt), 64'd4);
    check("t7_err_stick", 64'(err),     64'd1);
    check("t7_req_final", 64'(req_cnt), 64'd4);

    // Reset in DRAIN with 2 outstanding.
    ro_mode = 0; resp_delay = 40;
    clear_model();
    launch(2, 2'd2);
    wait_sent("rd_sent", 2);
    @(negedge clk);
    check("rd_busy_drain", 64'(busy), 64'd1);
    check("rd_outst",      64'(sent_n - done_bursts), 64'd2);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("rd_req_so",  64'(req_so),  64'd0);
    check("rd_req_do",  req_do,       64'd0);
    check("rd_rsp_ri",  64'(rsp_ri),  64'd0);
    check("rd_busy",    64'(busy),    64'd0);
    check("rd_done",    64'(done),    64'd0);
    check("rd_req_cnt", 64'(req_cnt), 64'd0);
    check("rd_rsp_cnt", 64'(rsp_cnt), 64'd0);
    check("rd_err",     64'(err),     64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    req_so_seen = 1'b0;
    done_pulses = 0;
    repeat (50) @(negedge clk);
    check("rd_no_req_after", 64'(req_so_seen), 64'd0);
    check("rd_no_done",      64'(done_pulses), 64'd0);
    check("rd_idle",         64'(busy),        64'd0);
    check("rd_ri_low",       64'(rsp_ri),      64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
